// File: rtl/mips_mc_control_fsm.sv
// Main control sequencer for the multi-cycle MIPS datapath: steps FETCH/DECODE/EXEC/MEM/WB,
// counts retired instructions and traps illegal opcodes and memory timeouts.
module mips_mc_control_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic [1:0]       reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             InstDone,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_RTEXE  = 4'd7,
    S_ALUWB  = 4'd8,  S_BEQ   = 4'd9,  S_IEXE   = 4'd10, S_IWB    = 4'd11,
    S_JUMP   = 4'd12, S_JAL   = 4'd13, S_TRAP   = 4'd14
  } state_e;

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               jr_q, jr_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               in_wait;
  logic               unused_zero;

  // The branch decision is made in the datapath; zero is part of the interface only.
  assign unused_zero = zero;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      jr_q      <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      jr_q      <= jr_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      retired_q <= retired_d;
    end
  end

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    jr_d          = jr_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    retired_d     = retired_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 2'd0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    pc_source     = 2'd0;
    InstDone      = 1'b0;

    // Wait counter runs only while a memory state stalls; any other cycle clears it.
    if (in_wait && !mem_ready) wait_d = wait_q + 1'b1;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        jr_d      = (opcode == 6'h00) && (funct == 6'h08);
        case (opcode)
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h00:        state_d = (funct == 6'h08) ? S_JUMP : S_RTEXE;
          6'h04:        state_d = S_BEQ;
          6'h08:        state_d = S_IEXE;
          6'h02:        state_d = S_JUMP;
          6'h03:        state_d = S_JAL;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        InstDone   = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        InstDone  = mem_ready;
      end
      S_RTEXE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 2'd1;
        reg_write = 1'b1;
        InstDone  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        InstDone      = 1'b1;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        InstDone  = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = jr_q ? 2'd3 : 2'd2;
        InstDone  = 1'b1;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        reg_dst   = 2'd2;
        reg_write = 1'b1;
        InstDone  = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase

    if (InstDone) begin
      state_d   = S_FETCH;
      retired_d = retired_q + 1'b1;
    end

    if (in_wait && !mem_ready && (wait_q == WAIT_W'(MEM_WAIT_MAX - 1))) begin
      state_d   = S_TRAP;
      bus_err_d = 1'b1;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// Self-checking bench for mips_mc_control_fsm: table of instruction sequences, directed
// corner cases (fetch stall, bus timeout, illegal opcode, async abort) and a random stream.
module tb_mips_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
  logic [1:0]  reg_dst, alu_src_b, alu_op, pc_source;
  logic        reg_write, alu_src_a, InstDone, illegal, bus_err;
  logic [31:0] retired;
  logic [3:0]  state;
  logic [17:0] ctrl;

  int errors = 0;
  int checks = 0;
  int model_ret = 0;
  logic [1:0] model_flags = 2'b00;  // {illegal, bus_err}
  logic cur_jr = 1'b0;

  mips_mc_control_fsm #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .InstDone(InstDone), .illegal(illegal), .bus_err(bus_err),
    .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, InstDone};

  // Control word each state should show, straight from the state descriptions.
  function automatic logic [17:0] exp_ctrl(input int s, input logic mr, input logic jr);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rw, asa, done;
    logic [1:0] rd, asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rw, asa, done} = '0;
    {rd, asb, aop, psrc} = '0;
    case (s)
      1:  begin mrd = 1; asb = 1; pw = mr; irw = mr; end
      2:  asb = 3;
      3:  begin asa = 1; asb = 2; end
      4:  begin iod = 1; mrd = 1; end
      5:  begin m2r = 1; rw = 1; done = 1; end
      6:  begin iod = 1; mwr = 1; done = mr; end
      7:  begin asa = 1; aop = 2; end
      8:  begin rd = 1; rw = 1; done = 1; end
      9:  begin asa = 1; aop = 1; pwc = 1; psrc = 1; done = 1; end
      10: begin asa = 1; asb = 2; end
      11: begin rw = 1; done = 1; end
      12: begin pw = 1; psrc = jr ? 2'd3 : 2'd2; done = 1; end
      13: begin pw = 1; psrc = 2; rd = 2; rw = 1; done = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input int es, input logic mr);
    logic [17:0] e;
    e = exp_ctrl(es, mr, cur_jr);
    check("state", 32'(state), 32'(es));
    check("ctrl", 32'(ctrl), 32'(e));
    check("retired", retired, 32'(model_ret));
    check("flags", 32'({illegal, bus_err}), 32'(model_flags));
    if (e[0]) model_ret++;
  endtask

  // One clock: drive at the falling edge, compare 1 ns later, well before the rising edge.
  task automatic cycle(input int es, input logic mr);
    @(negedge clk);
    mem_ready = mr;
    zero      = 1'($urandom);
    #1;
    check_all(es, mr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    model_ret = 0;
    model_flags = 2'b00;
    check_all(0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all(0, 1'b1);
  endtask

  // Expected state trace of one instruction from its class and the chosen stall lengths.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    opcode = op;
    funct  = fn;
    cur_jr = (op == 6'h00) && (fn == 6'h08);
    for (int i = 0; i < fw; i++) cycle(1, 1'b0);
    cycle(1, 1'b1);
    cycle(2, 1'($urandom));
    case (op)
      6'h23: begin
        cycle(3, 1'($urandom));
        for (int i = 0; i < mw; i++) cycle(4, 1'b0);
        cycle(4, 1'b1);
        cycle(5, 1'($urandom));
      end
      6'h2B: begin
        cycle(3, 1'($urandom));
        for (int i = 0; i < mw; i++) cycle(6, 1'b0);
        cycle(6, 1'b1);
      end
      6'h00: begin
        if (cur_jr) cycle(12, 1'($urandom));
        else begin
          cycle(7, 1'($urandom));
          cycle(8, 1'($urandom));
        end
      end
      6'h04: cycle(9, 1'($urandom));
      6'h08: begin
        cycle(10, 1'($urandom));
        cycle(11, 1'($urandom));
      end
      6'h02: cycle(12, 1'($urandom));
      6'h03: cycle(13, 1'($urandom));
      default: begin
        model_flags[1] = 1'b1;
        for (int i = 0; i < 3; i++) cycle(14, 1'($urandom));
      end
    endcase
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    int          n;
    logic [19:0] seq;  // state codes, first state in the low nibble
  } vec_t;

  vec_t vecs[8];
  logic [5:0] rand_ops[8];

  initial begin
    vecs[0] = '{op: 6'h23, fn: 6'h00, n: 5, seq: 20'h54321};
    vecs[1] = '{op: 6'h00, fn: 6'h20, n: 4, seq: 20'h08721};
    vecs[2] = '{op: 6'h2B, fn: 6'h00, n: 4, seq: 20'h06321};
    vecs[3] = '{op: 6'h04, fn: 6'h00, n: 3, seq: 20'h00921};
    vecs[4] = '{op: 6'h08, fn: 6'h00, n: 4, seq: 20'h0BA21};
    vecs[5] = '{op: 6'h02, fn: 6'h00, n: 3, seq: 20'h00C21};
    vecs[6] = '{op: 6'h03, fn: 6'h00, n: 3, seq: 20'h00D21};
    vecs[7] = '{op: 6'h00, fn: 6'h08, n: 3, seq: 20'h00C21};
    rand_ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h08, 6'h02, 6'h03};

    rst = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    check_all(0, 1'b0);
    do_reset();

    // Table: each instruction class with memory always ready.
    foreach (vecs[v]) begin
      opcode = vecs[v].op;
      funct  = vecs[v].fn;
      cur_jr = (vecs[v].op == 6'h00) && (vecs[v].fn == 6'h08);
      for (int k = 0; k < vecs[v].n; k++) cycle(int'(vecs[v].seq[4*k +: 4]), 1'b1);
    end

    // beq with both zero values behaves the same from the controller's side.
    opcode = 6'h04;
    for (int z = 0; z < 2; z++) begin
      cycle(1, 1'b1); cycle(2, 1'b1);
      @(negedge clk); mem_ready = 1'b1; zero = 1'(z); #1; check_all(9, 1'b1);
    end

    // FETCH stalled three cycles, lw read stalled 14 cycles (one short of timeout).
    run_instr(6'h23, 6'h00, 3, 14);
    run_instr(6'h2B, 6'h00, 2, 5);

    // Read stuck low: fifteen stalled MEMRD cycles, then TRAP with bus_err.
    do_reset();
    opcode = 6'h23;
    cycle(1, 1'b1); cycle(2, 1'b1); cycle(3, 1'b1);
    for (int i = 0; i < 15; i++) cycle(4, 1'b0);
    model_flags[0] = 1'b1;
    for (int i = 0; i < 4; i++) cycle(14, 1'($urandom));

    // Illegal opcode.
    do_reset();
    run_instr(6'h3F, 6'h00, 0, 0);

    // Reset asserted mid-MEMWR aborts at once.
    do_reset();
    run_instr(6'h23, 6'h00, 0, 0);
    opcode = 6'h2B; cur_jr = 1'b0;
    cycle(1, 1'b1); cycle(2, 1'b1); cycle(3, 1'b1); cycle(6, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    model_ret = 0;
    model_flags = 2'b00;
    check_all(0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all(0, 1'b0);
    cycle(1, 1'b1);
    cycle(2, 1'b1);
    cycle(3, 1'b1);
    cycle(6, 1'b1);

    // Random instruction stream with random stalls.
    for (int n = 0; n < 60; n++) begin
      int idx;
      logic [5:0] fn;
      idx = int'($urandom_range(0, 7));
      fn  = (idx == 3) ? 6'h08 : 6'($urandom_range(32, 42));
      run_instr(rand_ops[idx], fn, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
